mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
Shares one sram-like memory bus between the instruction-fetch port (IF) and the data port (MEM) of the five-stage pipeline. It raises per-port stall requests to the hazard unit and runs at most one outstanding transaction. Returned data is held until the pipeline advances, so a stalled stage never re-issues an access. It sits between the datapath's fetch/data memory ports and the external bus bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active low
i_req  in  1  IF fetch request, level; high while PCF is valid
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetched instruction, held
i_stall  out  1  IF stall request
d_req  in  1  MEM access request, level (MemEnableM)
d_wen  in  4  byte write enables; nonzero means write
d_size  in  2  0=byte, 1=half, 2=word
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, held
d_stall  out  1  MEM stall request
cpu_stall  in  1  global pipeline stall; high means no stage advances
i_flush  in  1  fetch redirect (exception/eret/branch flush)
mem_req  out  1  bus request
mem_wr  out  1  bus write
mem_size  out  2  bus size
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_addr_ok  in  1  address accepted
mem_data_ok  in  1  data returned / write done
mem_rdata  in  DATA_W  bus read data

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; mem_req=0; mem_wr=0; mem_size=0; mem_addr=0; mem_wdata=0; i_rdata=0; d_rdata=0; i_done=d_done=0; discard=0.
- FSM states: IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA.
- IDLE arbitration:
  - Data wins: if d_req & ~d_done, go to D_ADDR.
  - Otherwise, if i_req & ~i_done & ~i_flush, go to I_ADDR.
- Bus fields are registered on entry to *_ADDR and held stable until addr_ok.
- mem_req is high only in *_ADDR.
- mem_wr = |d_wen for data accesses and 0 for fetches. Fetch size is always 2.
- *_ADDR to *_DATA on mem_addr_ok.
- *_DATA to IDLE on mem_data_ok:
  - mem_rdata is captured into d_rdata / i_rdata.
  - The matching done flag is set; for a fetch, only if ~discard.
- The slave never asserts data_ok in the same cycle as addr_ok. One cycle is the minimum addr_ok-to-data_ok latency.
- Stall outputs: i_stall = i_req & ~i_done; d_stall = d_req & ~d_done. Both are combinational.
- Done flags clear on any cycle with cpu_stall==0, when the pipeline advances. Captured data stays valid while cpu_stall==1.
- Flush handling:
  - i_flush in I_ADDR before addr_ok: drop mem_req and go to IDLE.
  - i_flush in I_DATA, or with addr_ok in the same cycle: set discard. The transaction completes, i_done is not set, and discard clears on data_ok.
  - i_flush also clears i_done.
- Data requests are never flushed once issued. MEM commits precisely.
- Simultaneous completion and new request: go to IDLE first. The next grant takes effect the cycle after, so there is one bubble cycle per transaction.
- Best case is 3 cycles per access: the ADDR cycle with addr_ok, the DATA cycle with data_ok, then IDLE.
- Reset mid-transaction abandons it; the bridge is reset together with this block.

Optional Feature:
ARB_PERF_CNT_EN.
- Defined: 32-bit outputs perf_istall_cnt and perf_dstall_cnt count cycles with i_stall / d_stall high. They reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent and the rest of the behaviour is unchanged.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=0, D_ADDR=1, D_DATA=2, I_ADDR=3, I_DATA=4;
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD.
- One sub-module, arb_hold_reg: a data register plus done flag with capture, clear-on-advance and discard logic, instantiated once per port.

Test Plan:
- Fetch only: i_addr=0xbfc00000, addr_ok at cycle 1, data_ok at cycle 3 with rdata=0x24010001 -> i_stall high for cycles 0-3, then low; i_rdata=0x24010001.
- Both requests in IDLE (i_addr=0x100, d_addr=0x200) -> first mem_addr=0x200 with mem_wr=0; the fetch is granted only after d data_ok.
- Store with d_wen=4'b0011, d_size=1, d_wdata=0xdeadbeef -> mem_wr=1, mem_size=1, mem_wdata=0xdeadbeef; d_stall drops after data_ok.
- cpu_stall held high for 5 cycles after a load returns 0x55 -> d_rdata stays 0x55, d_stall stays 0, and there is no second mem_req.
- i_flush during I_DATA, then data_ok with 0x1234 -> i_done stays 0 and i_rdata is not used; the next fetch issues with the new i_addr.
- rst=0 asserted in D_DATA -> the next cycle has state IDLE, mem_req=0, both stalls following the request inputs, and ARB_PERF_CNT_EN counters at 0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the IF/MEM memory bus arbiter:
//   - FSM state encoding (IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA)
//   - bus size codes (byte / half / word)
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] D_ADDR = 3'd1;
    localparam logic [2:0] D_DATA = 3'd2;
    localparam logic [2:0] I_ADDR = 3'd3;
    localparam logic [2:0] I_DATA = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_D_ADDR = D_ADDR,
        ST_D_DATA = D_DATA,
        ST_I_ADDR = I_ADDR,
        ST_I_DATA = I_DATA
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_arb_hold_reg.sv
// ---------------------------------------------------------------------------
// arb_hold_reg
// Holds the data returned for one pipeline port together with its done flag.
// The done flag tells the port that its access has completed, so the stage
// does not re-issue it while the pipeline is stalled.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   capture      bus data returned for this port this cycle
//   discard      returned data belongs to a squashed access; do not mark done
//   clear        pipeline advances (or fetch redirect): drop the done flag
//   rdata_in     bus read data
//   data         held data
//   done         access of this port has completed
// ---------------------------------------------------------------------------
module arb_hold_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              discard,
    input  logic              clear,
    input  logic [DATA_W-1:0] rdata_in,
    output logic [DATA_W-1:0] data,
    output logic              done
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            data <= '0;
            done <= 1'b0;
        end else begin
            if (capture) begin
                data <= rdata_in;
            end
            // A completion wins over a simultaneous clear: the stage has not
            // yet seen the data, so it must stay marked done for the next cycle.
            if (capture && !discard) begin
                done <= 1'b1;
            end else if (clear) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one sram-like bus between instruction fetch (IF) and data (MEM).
// One outstanding transaction at a time; data port has priority. Returned
// data is held (with a done flag) until the pipeline advances so a stalled
// stage never re-issues its access. Fetches can be squashed by i_flush.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   i_req/i_addr/i_rdata/i_stall   fetch port
//   d_req/d_wen/d_size/d_addr/d_wdata/d_rdata/d_stall  data port
//   cpu_stall                      global pipeline stall
//   i_flush                        fetch redirect
//   mem_*                          bus towards the bridge
// Optional (macro ARB_PERF_CNT_EN):
//   perf_istall_cnt, perf_dstall_cnt  cycles with i_stall / d_stall high
// ---------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic [3:0]        d_wen,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    input  logic              cpu_stall,
    input  logic              i_flush,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_istall_cnt,
    output logic [31:0]       perf_dstall_cnt
`endif
);

    arb_state_t        state_reg, state_next;
    logic              discard_reg;
    logic              wr_reg;
    logic [1:0]        size_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic load_d, load_i, cap_d, cap_i;
    logic i_done, d_done;
    logic i_discard;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        load_d     = 1'b0;
        load_i     = 1'b0;
        cap_d      = 1'b0;
        cap_i      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (d_req && !d_done) begin
                    state_next = ST_D_ADDR;
                    load_d     = 1'b1;
                end else if (i_req && !i_done && !i_flush) begin
                    state_next = ST_I_ADDR;
                    load_i     = 1'b1;
                end
            end
            ST_D_ADDR: begin
                if (mem_addr_ok) state_next = ST_D_DATA;
            end
            ST_D_DATA: begin
                if (mem_data_ok) begin
                    state_next = ST_IDLE;
                    cap_d      = 1'b1;
                end
            end
            ST_I_ADDR: begin
                // Once the address is accepted the fetch must be completed,
                // even if flushed in the same cycle.
                if (mem_addr_ok)  state_next = ST_I_DATA;
                else if (i_flush) state_next = ST_IDLE;
            end
            ST_I_DATA: begin
                if (mem_data_ok) begin
                    state_next = ST_IDLE;
                    cap_i      = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // ---------------- bus field registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_reg    <= 1'b0;
            size_reg  <= SZ_BYTE;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (load_d) begin
            wr_reg    <= |d_wen;
            size_reg  <= d_size;
            addr_reg  <= d_addr;
            wdata_reg <= d_wdata;
        end else if (load_i) begin
            wr_reg    <= 1'b0;
            size_reg  <= SZ_WORD;
            addr_reg  <= i_addr;
        end
    end

    // ---------------- fetch discard tracking ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            discard_reg <= 1'b0;
        end else if (state_reg == ST_I_ADDR && mem_addr_ok && i_flush) begin
            discard_reg <= 1'b1;
        end else if (state_reg == ST_I_DATA) begin
            if (mem_data_ok)  discard_reg <= 1'b0;
            else if (i_flush) discard_reg <= 1'b1;
        end
    end

    // A flush arriving together with data_ok squashes that fetch as well.
    assign i_discard = discard_reg | (state_reg == ST_I_DATA && i_flush);

    // ---------------- per-port hold registers ----------------
    arb_hold_reg #(.DATA_W(DATA_W)) u_hold_i (
        .clk      (clk),
        .rst      (rst),
        .capture  (cap_i),
        .discard  (i_discard),
        .clear    (!cpu_stall || i_flush),
        .rdata_in (mem_rdata),
        .data     (i_rdata),
        .done     (i_done)
    );

    arb_hold_reg #(.DATA_W(DATA_W)) u_hold_d (
        .clk      (clk),
        .rst      (rst),
        .capture  (cap_d),
        .discard  (1'b0),
        .clear    (!cpu_stall),
        .rdata_in (mem_rdata),
        .data     (d_rdata),
        .done     (d_done)
    );

    // ---------------- outputs ----------------
    assign mem_req   = (state_reg == ST_D_ADDR) || (state_reg == ST_I_ADDR);
    assign mem_wr    = wr_reg;
    assign mem_size  = size_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_istall_cnt <= '0;
            perf_dstall_cnt <= '0;
        end else begin
            if (i_stall) perf_istall_cnt <= perf_istall_cnt + 32'd1;
            if (d_stall) perf_dstall_cnt <= perf_dstall_cnt + 32'd1;
        end
    end
`endif

endmodule
